spike_localizer: RTL and testbench

// Receiver for the spike grouper's grouped-event stream (time, x_acc, y_acc, a_acc, tvalid/tready, tlast).

---
 rtl/spike_localizer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_spike_localizer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_localizer.sv
// spike_localizer: receives grouped spike events (time, x_acc, y_acc, a_acc)
// under a one-cycle credit protocol. Events are buffered in a small FIFO and
// localized by an amplitude-weighted centroid:
//   x = (x_acc << FRAC_BITS) / a_acc,  y = (y_acc << FRAC_BITS) / a_acc
// Both quotients come from a shared-control restoring divider that produces
// one bit per cycle. Results leave on an AXI-Stream master. The
// end-of-recording marker is forwarded once all buffered events have drained.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axis_b_*          event input; tvalid is a single-cycle pulse that must
//                       follow a cycle in which tready was high; tlast is an
//                       independent end-of-stream pulse
//   m_axis_*            localized spike output (time, x, y, valid/ready,
//                       tlast pulse)
//   overflow            sticky flag: a beat was dropped for lack of credit
module spike_localizer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POS_W      = 16,
  parameter int unsigned FRAC_BITS  = 4,
  parameter int unsigned TIME_W     = 32,
  parameter int unsigned XACC_W     = 24,
  parameter int unsigned YACC_W     = 24,
  parameter int unsigned AACC_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TIME_W-1:0] s_axis_b_time,
  input  logic [XACC_W-1:0] s_axis_b_tx,
  input  logic [YACC_W-1:0] s_axis_b_ty,
  input  logic [AACC_W-1:0] s_axis_b_ta,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic              s_axis_b_tlast,
  output logic [TIME_W-1:0] m_axis_time,
  output logic [POS_W-1:0]  m_axis_tx,
  output logic [POS_W-1:0]  m_axis_ty,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              overflow
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned ITER_W = (POS_W > 1) ? $clog2(POS_W) : 1;
  localparam int unsigned DIV_W  = AACC_W + POS_W;
  localparam int unsigned XN_W   = XACC_W + FRAC_BITS;
  localparam int unsigned YN_W   = YACC_W + FRAC_BITS;
  localparam int unsigned XY_W   = (XN_W > YN_W) ? XN_W : YN_W;
  localparam int unsigned CMP_W  = (XY_W > DIV_W) ? XY_W : DIV_W;

  typedef struct packed {
    logic [TIME_W-1:0] t;
    logic [XACC_W-1:0] x;
    logic [YACC_W-1:0] y;
    logic [AACC_W-1:0] a;
  } evt_t;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

  // One restoring-division step: the upper AACC_W bits hold the partial
  // remainder, the lower POS_W bits shift out numerator bits and shift in
  // quotient bits.
  function automatic logic [DIV_W-1:0] div_step(input logic [DIV_W-1:0] acc,
                                                 input logic [AACC_W-1:0] den);
    logic [DIV_W:0]  sh;
    logic [AACC_W:0] hi;
    sh = {acc, 1'b0};
    hi = sh[DIV_W -: AACC_W+1];
    if (hi >= {1'b0, den}) begin
      hi    = hi - {1'b0, den};
      sh[0] = 1'b1;
    end
    return {hi[AACC_W-1:0], sh[POS_W-1:0]};
  endfunction

  // FIFO state
  evt_t             mem_q [FIFO_DEPTH];
  evt_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rdy_q, rdy_d;

  // Divider / FSM state
  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [DIV_W-1:0]  acc_x_q, acc_x_d;
  logic [DIV_W-1:0]  acc_y_q, acc_y_d;
  logic [AACC_W-1:0] den_q, den_d;
  logic              sat_x_q, sat_x_d;
  logic              sat_y_q, sat_y_d;
  logic [TIME_W-1:0] op_time_q, op_time_d;

  // Output registers
  logic [TIME_W-1:0] m_time_q, m_time_d;
  logic [POS_W-1:0]  m_tx_q, m_tx_d;
  logic [POS_W-1:0]  m_ty_q, m_ty_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              m_tlast_q, m_tlast_d;
  logic              overflow_q, overflow_d;
  logic              pending_q, pending_d;

  logic              push, pop, fire_last;
  evt_t              in_evt, head;
  logic [CMP_W-1:0]  xn_ext, yn_ext, den_ext;
  logic [DIV_W-1:0]  step_x, step_y;

  // Credit counts both stored entries and the beat that may arrive next cycle.
  assign s_axis_b_tready = (SUM_W'(count_q) + SUM_W'(rdy_q)) < SUM_W'(FIFO_DEPTH);

  assign in_evt = '{t: s_axis_b_time, x: s_axis_b_tx, y: s_axis_b_ty, a: s_axis_b_ta};
  assign head   = mem_q[rd_ptr_q];

  assign push      = s_axis_b_tvalid & rdy_q & (count_q < CNT_W'(FIFO_DEPTH));
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign fire_last = pending_q & (count_q == '0) & (state_q == S_IDLE) & ~push;

  // Numerators and scaled denominator in a common width for the saturation test
  assign xn_ext  = CMP_W'(head.x) << FRAC_BITS;
  assign yn_ext  = CMP_W'(head.y) << FRAC_BITS;
  assign den_ext = CMP_W'(head.a) << POS_W;

  assign step_x = div_step(acc_x_q, den_q);
  assign step_y = div_step(acc_y_q, den_q);

  // FIFO, credit and end-of-stream bookkeeping
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rdy_d      = s_axis_b_tready;
    overflow_d = overflow_q;
    pending_d  = pending_q;
    m_tlast_d  = 1'b0;

    if (push) begin
      mem_d[wr_ptr_q] = in_evt;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (s_axis_b_tvalid && !push) begin
      overflow_d = 1'b1;
    end

    // A tlast arriving while one is already pending is absorbed.
    if (fire_last) begin
      m_tlast_d = 1'b1;
      pending_d = 1'b0;
    end else if (s_axis_b_tlast) begin
      pending_d = 1'b1;
    end
  end

  // Localizer FSM: IDLE pops, DIV iterates, OUT holds the result until accepted
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    den_d      = den_q;
    sat_x_d    = sat_x_q;
    sat_y_d    = sat_y_q;
    op_time_d  = op_time_q;
    m_time_d   = m_time_q;
    m_tx_d     = m_tx_q;
    m_ty_d     = m_ty_q;
    m_tvalid_d = m_tvalid_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (head.a == '0) begin
            // Zero amplitude: report the origin without dividing.
            m_time_d   = head.t;
            m_tx_d     = '0;
            m_ty_d     = '0;
            m_tvalid_d = 1'b1;
            state_d    = S_OUT;
          end else begin
            op_time_d = head.t;
            den_d     = head.a;
            sat_x_d   = xn_ext >= den_ext;
            sat_y_d   = yn_ext >= den_ext;
            // Truncation is safe whenever the quotient does not saturate.
            acc_x_d   = DIV_W'(xn_ext);
            acc_y_d   = DIV_W'(yn_ext);
            iter_d    = ITER_W'(POS_W - 1);
            state_d   = S_DIV;
          end
        end
      end

      S_DIV: begin
        acc_x_d = step_x;
        acc_y_d = step_y;
        if (iter_q == '0) begin
          m_time_d   = op_time_q;
          m_tx_d     = sat_x_q ? {POS_W{1'b1}} : step_x[POS_W-1:0];
          m_ty_d     = sat_y_q ? {POS_W{1'b1}} : step_y[POS_W-1:0];
          m_tvalid_d = 1'b1;
          state_d    = S_OUT;
        end else begin
          iter_d = iter_q - 1'b1;
        end
      end

      S_OUT: begin
        if (m_axis_tready) begin
          m_tvalid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        m_tvalid_d = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdy_q      <= 1'b0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
      state_q    <= S_IDLE;
      iter_q     <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      den_q      <= '0;
      sat_x_q    <= 1'b0;
      sat_y_q    <= 1'b0;
      op_time_q  <= '0;
      m_time_q   <= '0;
      m_tx_q     <= '0;
      m_ty_q     <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rdy_q      <= rdy_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
      m_tlast_q  <= m_tlast_d;
      state_q    <= state_d;
      iter_q     <= iter_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      den_q      <= den_d;
      sat_x_q    <= sat_x_d;
      sat_y_q    <= sat_y_d;
      op_time_q  <= op_time_d;
      m_time_q   <= m_time_d;
      m_tx_q     <= m_tx_d;
      m_ty_q     <= m_ty_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign m_axis_time   = m_time_q;
  assign m_axis_tx     = m_tx_q;
  assign m_axis_ty     = m_ty_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_spike_localizer.sv
// Scoreboard bench for spike_localizer (POS_W=8, FRAC_BITS=4, FIFO_DEPTH=4).
module tb_spike_localizer;

  localparam int unsigned POS_W  = 8;
  localparam int unsigned TIME_W = 32;
  localparam int unsigned XACC_W = 24;
  localparam int unsigned YACC_W = 24;
  localparam int unsigned AACC_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [TIME_W-1:0] s_time;
  logic [XACC_W-1:0] s_tx;
  logic [YACC_W-1:0] s_ty;
  logic [AACC_W-1:0] s_ta;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;
  logic [TIME_W-1:0] m_time;
  logic [POS_W-1:0]  m_tx;
  logic [POS_W-1:0]  m_ty;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              overflow;

  spike_localizer #(
    .FIFO_DEPTH(4), .POS_W(POS_W), .FRAC_BITS(4),
    .TIME_W(TIME_W), .XACC_W(XACC_W), .YACC_W(YACC_W), .AACC_W(AACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_b_time(s_time), .s_axis_b_tx(s_tx), .s_axis_b_ty(s_ty),
    .s_axis_b_ta(s_ta), .s_axis_b_tvalid(s_tvalid), .s_axis_b_tready(s_tready),
    .s_axis_b_tlast(s_tlast),
    .m_axis_time(m_time), .m_axis_tx(m_tx), .m_axis_ty(m_ty),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TIME_W-1:0] t;
    logic [POS_W-1:0]  x;
    logic [POS_W-1:0]  y;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   ncyc   = 0;
  int   last_hs = 0;
  int   tlast_cnt = 0;
  bit   tlast_gap_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: compares every accepted beat against the scoreboard head.
  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_time", m_time, e.t);
          chk("out_x", m_tx, e.x);
          chk("out_y", m_ty, e.y);
        end
        last_hs = ncyc;
      end
      if (m_tlast) begin
        tlast_cnt++;
        chk("tlast_with_valid", m_tvalid, 0);
        chk("tlast_sb_empty", sb.size(), 0);
        if (tlast_gap_en) chk("tlast_gap", ncyc - last_hs, 2);
      end
    end
  end

  // Waits for credit, then issues one single-cycle beat after the credit cycle.
  task automatic send(input int t, input int x, input int y, input int a,
                      input int ex, input int ey);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_credit_timeout", 1, 0);
    @(posedge clk); #1;
    s_tvalid = 1'b1;
    s_time = TIME_W'(t);
    s_tx = XACC_W'(x);
    s_ty = YACC_W'(y);
    s_ta = AACC_W'(a);
    sb.push_back('{t: TIME_W'(t), x: POS_W'(ex), y: POS_W'(ey)});
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  // Counts falling edges from the push edge until the result is presented.
  task automatic wait_valid(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!m_tvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, exp_lat);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_tvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk(name, 1, 0);
  endtask

  int  accepted;
  bit  give;

  initial begin
    rst_n = 1'b0; s_time = '0; s_tx = '0; s_ty = '0; s_ta = '0;
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tx", m_tx, 0);
    chk("rst_time", m_time, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic centroid, output held while downstream stalls
    send(1000, 300, 600, 100, 48, 96);
    wait_valid("lat_basic", 10);
    repeat (3) @(negedge clk);
    chk("hold_valid", m_tvalid, 1);
    chk("hold_x", m_tx, 48);
    chk("hold_y", m_ty, 96);
    m_tready = 1'b1;
    drain("drain_basic");

    // Zero amplitude skips the divider
    send(2000, 5, 7, 0, 0, 0);
    wait_valid("lat_div0", 2);
    drain("drain_div0");

    // Saturation and its boundary
    send(3000, 4096, 0, 1, 255, 0);
    wait_valid("lat_sat", 10);
    drain("drain_sat");
    send(3001, 15, 16, 1, 240, 255);
    drain("drain_bound");
    send(3002, 17, 33, 3, 90, 176);
    drain("drain_frac");

    // Credit: one result stalled in OUT, then fill the FIFO
    m_tready = 1'b0;
    send(4000, 100, 200, 10, 160, 255);
    wait_valid("lat_credit0", 10);
    accepted = 0;
    repeat (20) begin
      @(negedge clk);
      give = s_tready;
      @(posedge clk); #1;
      s_tvalid = give;
      if (give) begin
        s_time = TIME_W'(4100 + accepted);
        s_tx = XACC_W'(10 + accepted);
        s_ty = YACC_W'(3 * accepted + 1);
        s_ta = AACC_W'(2);
        sb.push_back('{t: TIME_W'(4100 + accepted), x: POS_W'((10 + accepted) * 8),
                       y: POS_W'((3 * accepted + 1) * 8)});
        accepted++;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("credit_accepted", accepted, 4);
    chk("credit_tready_low", s_tready, 0);
    chk("credit_no_overflow", overflow, 0);
    // Beat without credit is dropped
    @(posedge clk); #1;
    s_tvalid = 1'b1; s_time = 32'd9999; s_tx = 24'd1; s_ty = 24'd1; s_ta = 16'd1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("overflow_set", overflow, 1);
    m_tready = 1'b1;
    drain("drain_credit");
    chk("overflow_sticky", overflow, 1);

    // End-of-stream marker after three events, tlast pulsed twice during DIV
    tlast_cnt = 0;
    tlast_gap_en = 1'b1;
    send(5000, 32, 64, 4, 128, 255);
    send(5001, 8, 8, 2, 64, 64);
    send(5002, 0, 15, 3, 0, 80);
    @(posedge clk); #1; s_tlast = 1'b1;
    @(posedge clk); #1; s_tlast = 1'b0;
    @(posedge clk); #1; s_tlast = 1'b1;
    @(posedge clk); #1; s_tlast = 1'b0;
    drain("drain_tlast");
    repeat (10) @(negedge clk);
    chk("tlast_once", tlast_cnt, 1);
    tlast_gap_en = 1'b0;

    // Async reset while dividing with two events queued
    send(5500, 100, 100, 7, 228, 228);
    send(5501, 1, 1, 1, 16, 16);
    send(5502, 2, 2, 1, 32, 32);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_tvalid", m_tvalid, 0);
    chk("amid_tx", m_tx, 0);
    chk("amid_ty", m_ty, 0);
    chk("amid_overflow", overflow, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(6000, 50, 25, 5, 160, 80);
    wait_valid("lat_post_rst", 10);
    drain("drain_post_rst");
    repeat (5) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
